// File: rtl/fifo9_frame_rx_if.sv
// fifo9_frame_rx_if: FIFO read port plus delimited byte stream of the GMII frame receiver.
interface fifo9_frame_rx_if;
  logic [8:0] dout;
  logic       empty;
  logic       rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;
  modport slave (input dout, empty, output rd_en, out_data, out_valid, out_sof, out_eof, out_err);
  modport master(output dout, empty, input rd_en, out_data, out_valid, out_sof, out_eof, out_err);
endinterface

// File: rtl/fifo9_frame_rx.sv
// fifo9_frame_rx: strips preamble/SFD from 9-bit GMII FIFO words, emits sof/eof/err byte stream with stats.
// Optional FCS check enabled by defining CRC_CHECK_EN.
module fifo9_frame_rx #(
  parameter logic [15:0] MinLen = 16'd64,
  parameter logic [15:0] MaxLen = 16'd1518
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  fifo9_frame_rx_if.slave      bus,
  output logic [31:0]          frame_cnt,
  output logic [15:0]          err_cnt,
  output logic [15:0]          pre_err_cnt
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  state_t r_state, w_next;
  logic       w_rd, w_rxc, w_is_pre, w_is_sfd;
  logic [7:0] w_byte;
  logic       w_start, w_take, w_emit, w_eof, w_pre_err, w_err, w_fcs_bad;
  logic [7:0] r_hold, r_out_data;
  logic       r_hold_v, r_hold_sof, r_out_valid, r_out_sof, r_out_eof, r_out_err;
  logic [15:0] r_len;
  assign w_rd     = ~bus.empty;
  assign w_rxc    = bus.dout[8];
  assign w_byte   = bus.dout[7:0];
  assign w_is_pre = w_byte == 8'h55;
  assign w_is_sfd = w_byte == 8'hD5;
  assign bus.rd_en     = w_rd;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_eof   = r_out_eof;
  assign bus.out_err   = r_out_err;
`ifdef CRC_CHECK_EN
  logic [31:0] r_crc;
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction
  // Running CRC over DA..FCS lands on the fixed residue when the FCS is intact
  assign w_fcs_bad = r_crc != 32'hDEBB20E3;
`else
  assign w_fcs_bad = 1'b0;
`endif
  assign w_err = (r_len < MinLen) | (r_len > MaxLen) | w_fcs_bad;
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_take    = 1'b0;
    w_emit    = 1'b0;
    w_eof     = 1'b0;
    w_pre_err = 1'b0;
    if (w_rd) begin
      case (r_state)
        IDLE: if (w_rxc) begin
          w_next    = w_is_pre ? PRE : w_is_sfd ? DATA : DROP;
          w_start   = w_is_sfd;
          w_pre_err = !w_is_pre && !w_is_sfd;
        end
        PRE: begin
          w_next    = !w_rxc ? IDLE : w_is_sfd ? DATA : w_is_pre ? PRE : DROP;
          w_start   = w_rxc && w_is_sfd;
          w_pre_err = !w_rxc || (!w_is_pre && !w_is_sfd);
        end
        DATA: begin
          w_next    = w_rxc ? DATA : IDLE;
          w_take    = w_rxc;
          w_emit    = r_hold_v;
          w_eof     = !w_rxc && r_hold_v;
          w_pre_err = !w_rxc && !r_hold_v;
        end
        DROP: w_next = w_rxc ? DROP : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold      <= 8'd0;
      r_hold_v    <= 1'b0;
      r_hold_sof  <= 1'b0;
      r_len       <= 16'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_err   <= 1'b0;
      frame_cnt   <= 32'd0;
      err_cnt     <= 16'd0;
      pre_err_cnt <= 16'd0;
`ifdef CRC_CHECK_EN
      r_crc       <= 32'hFFFFFFFF;
`endif
    end else begin
      r_out_valid <= w_emit;
      r_out_sof   <= w_emit && r_hold_sof;
      r_out_eof   <= w_eof;
      r_out_err   <= w_eof && w_err;
      if (w_emit) r_out_data <= r_hold;
      if (w_start) begin
        r_hold_v <= 1'b0;
        r_len    <= 16'd0;
`ifdef CRC_CHECK_EN
        r_crc    <= 32'hFFFFFFFF;
`endif
      end
      if (w_take) begin
        r_hold     <= w_byte;
        r_hold_v   <= 1'b1;
        r_hold_sof <= !r_hold_v;
        r_len      <= r_len + {15'd0, r_len != 16'hFFFF};
`ifdef CRC_CHECK_EN
        r_crc      <= crc8(r_crc, w_byte);
`endif
      end
      if (w_eof && !w_err) frame_cnt <= frame_cnt + 32'd1;
      if (w_eof && w_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (w_pre_err && pre_err_cnt != 16'hFFFF) pre_err_cnt <= pre_err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo9_frame_rx.sv
// tb_fifo9_frame_rx: directed checks of preamble stripping, framing, length/FCS errors and statistics.
module tb_fifo9_frame_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt, pre_err_cnt;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          stall = 1'b0;
  logic [10:0] q[$];
  logic [7:0]  fr[$];
  fifo9_frame_rx_if bus();
  fifo9_frame_rx dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus),
                      .frame_cnt(frame_cnt), .err_cnt(err_cnt), .pre_err_cnt(pre_err_cnt));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.out_valid) q.push_back({bus.out_err, bus.out_eof, bus.out_sof, bus.out_data});
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.empty = 1'b1;
    bus.dout = 9'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 q.delete();
  endtask
  task automatic send(input logic [8:0] w);
    if (stall && (cyc % 3) == 2) begin
      bus.empty = 1'b1;
      @(posedge clk);
      #1;
    end
    cyc++;
    bus.dout = w;
    bus.empty = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.empty = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Payload pattern followed by FCS = ~CRC32 of the payload, LSB byte first
  task automatic build(input int len, input int seed);
    logic [31:0] c;
    fr.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      fr.push_back(8'((i * 7 + seed) & 255));
      c = c ^ {24'd0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int b = 0; b < 4; b++) fr.push_back(c[8*b +: 8]);
  endtask
  task automatic send_frame();
    repeat (7) send(9'h155);
    send(9'h1D5);
    foreach (fr[i]) send({1'b1, fr[i]});
    send(9'h000);
    send(9'h000);
    idle(3);
  endtask
  task automatic check_frame(input string tag, input logic exp_err);
    int nbad, nsof, neof;
    nbad = 0; nsof = 0; neof = 0;
    foreach (q[i]) begin
      if (i >= fr.size() || q[i][7:0] !== fr[i]) nbad++;
      nsof += int'(q[i][8]);
      neof += int'(q[i][9]);
    end
    check({tag, "_len"}, 64'(q.size()), 64'(fr.size()));
    check({tag, "_data"}, 64'(nbad), 64'd0);
    check({tag, "_sof0"}, q.size() > 0 ? 64'(q[0][8]) : 64'hDEAD, 64'd1);
    check({tag, "_eof_last"}, q.size() > 0 ? 64'(q[$][9]) : 64'hDEAD, 64'd1);
    check({tag, "_err"}, q.size() > 0 ? 64'(q[$][10]) : 64'hDEAD, 64'(exp_err));
    check({tag, "_nflags"}, 64'({nsof[15:0], neof[15:0]}), 64'h0001_0001);
  endtask
  initial begin
    bus.empty = 1'b1;
    bus.dout = 9'd0;
    do_reset();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_eof", 64'({bus.out_sof, bus.out_eof, bus.out_err}), 64'd0);
    check("rst_cnts", {frame_cnt, err_cnt, pre_err_cnt}, 64'd0);
    check("rd_en_idle", 64'(bus.rd_en), 64'd0);
    bus.empty = 1'b0;
    #1 check("rd_en_comb", 64'(bus.rd_en), 64'd1);
    bus.empty = 1'b1;
    // Test 1: good 64-byte frame
    do_reset();
    build(64, 3);
    send_frame();
    check_frame("t1", 1'b0);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_err_cnt", 64'(err_cnt), 64'd0);
    // Test 2: corrupted payload bit
    do_reset();
    build(64, 3);
    fr[20] = fr[20] ^ 8'h10;
    send_frame();
`ifdef CRC_CHECK_EN
    check_frame("t2", 1'b1);
    check("t2_cnts", {frame_cnt, err_cnt}, {32'd0, 16'd1});
`else
    check_frame("t2", 1'b0);
    check("t2_cnts", {frame_cnt, err_cnt}, {32'd1, 16'd0});
`endif
    // Test 3: runt then giant
    do_reset();
    build(60, 9);
    send_frame();
    check_frame("t3_runt", 1'b1);
    check("t3_runt_cnts", {frame_cnt, err_cnt}, {32'd0, 16'd1});
    q.delete();
    build(1519, 5);
    send_frame();
    check_frame("t3_giant", 1'b1);
    check("t3_giant_cnts", {frame_cnt, err_cnt}, {32'd0, 16'd2});
    q.delete();
    build(1518, 6);
    send_frame();
    check_frame("t3_max", 1'b0);
    check("t3_max_cnt", 64'(frame_cnt), 64'd1);
    // Test 4: preamble violations and 1-byte frame
    do_reset();
    send(9'h155); send(9'h155); send(9'h1AA); send(9'h112); send(9'h134);
    send(9'h000); send(9'h000);
    idle(3);
    check("t4_bad_pre_out", 64'(q.size()), 64'd0);
    check("t4_pre_err", 64'(pre_err_cnt), 64'd1);
    build(64, 11);
    send_frame();
    check_frame("t4_next", 1'b0);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd1);
    q.delete();
    send(9'h1D5); send(9'h000); idle(3);
    check("t4_sfd_gap", {32'(q.size()), 16'd0, pre_err_cnt}, {32'd0, 16'd0, 16'd2});
    send(9'h155); send(9'h000); idle(3);
    check("t4_pre_gap", 64'(pre_err_cnt), 64'd3);
    send(9'h1D5); send(9'h1AB); send(9'h000); idle(3);
    check("t4_one_byte", q.size() == 1 ? 64'(q[0]) : 64'hDEAD, 64'h7AB);
    check("t4_one_cnts", {frame_cnt, err_cnt}, {32'd1, 16'd1});
    // Test 5: FIFO empty 1-of-3 cycles
    do_reset();
    build(64, 3);
    stall = 1'b1;
    cyc = 0;
    send_frame();
    stall = 1'b0;
    check_frame("t5", 1'b0);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    // Test 6: reset mid-frame
    do_reset();
    build(64, 3);
    repeat (7) send(9'h155);
    send(9'h1D5);
    for (int i = 0; i < 30; i++) send({1'b1, fr[i]});
    check("t6_pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    bus.empty = 1'b1;
    #1;
    check("t6_rst_out", 64'({bus.out_valid, bus.out_sof, bus.out_eof, bus.out_err, bus.out_data}), 64'd0);
    check("t6_rst_cnts", {frame_cnt, err_cnt, pre_err_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 q.delete();
    build(64, 21);
    send_frame();
    check_frame("t6", 1'b0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
